// File: rtl/fir_input_sequencer.sv
// Drives the 4-tap FIR stage's shared input bus: reset pulse, mode word,
// coefficients (highest tap first), then FIFO-buffered samples.
module fir_input_sequencer #(
    parameter int N_TAPS     = 4,
    parameter int BW_IN      = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      lsb_mode,
    input  logic                      coef_we,
    input  logic [$clog2(N_TAPS)-1:0] coef_idx,
    input  logic [BW_IN-1:0]          coef_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [BW_IN-1:0]          s_data,
    output logic                      fir_reset,
    output logic [BW_IN-1:0]          fir_x,
    output logic                      busy,
    output logic                      out_valid,
    output logic                      out_lsb,
    output logic [7:0]                underrun_cnt
);

    localparam int IW = $clog2(N_TAPS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
    localparam logic [IW-1:0] TAP_ONE = IW'(1);
    localparam logic [IW-1:0] TAP_TOP = IW'(N_TAPS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RST    = 3'd1;
    localparam logic [2:0] S_MODE   = 3'd2;
    localparam logic [2:0] S_COEF   = 3'd3;
    localparam logic [2:0] S_STREAM = 3'd4;

    logic [2:0]       state, state_nx;
    logic             mode;
    logic             shift_cyc;
    logic             stop_pend;
    logic [IW-1:0]    tap_cnt, tap_nx;
    logic [BW_IN-1:0] coef_file [N_TAPS];
    logic [BW_IN-1:0] fifo_mem  [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;

    logic fifo_empty, fifo_full, push, pop;
    logic enter_read, enter_shift, stop_req;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign s_ready    = !fifo_full;
    assign push       = s_valid && !fifo_full;
    assign pop        = enter_read && !fifo_empty;
    assign stop_req   = stop || stop_pend;

    always_comb begin
        state_nx    = state;
        tap_nx      = tap_cnt;
        enter_read  = 1'b0;
        enter_shift = 1'b0;
        case (state)
            S_IDLE: if (start) state_nx = S_RST;
            S_RST:  state_nx = S_MODE;
            S_MODE: begin
                state_nx = S_COEF;
                tap_nx   = TAP_TOP;
            end
            S_COEF: begin
                if (tap_cnt == '0) begin
                    state_nx   = S_STREAM;
                    enter_read = 1'b1;
                end else begin
                    tap_nx = tap_cnt - TAP_ONE;
                end
            end
            S_STREAM: begin
                // In LSB mode a stop seen on a read cycle waits for the paired shift cycle
                if (stop_req && (!mode || shift_cyc)) begin
                    state_nx = S_IDLE;
                end else if (mode && !shift_cyc) begin
                    enter_shift = 1'b1;
                end else begin
                    enter_read = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            mode         <= 1'b0;
            shift_cyc    <= 1'b0;
            stop_pend    <= 1'b0;
            tap_cnt      <= '0;
            coef_file    <= '{default: '0};
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fir_reset    <= 1'b1;
            fir_x        <= '0;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            out_lsb      <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            state     <= state_nx;
            tap_cnt   <= tap_nx;
            shift_cyc <= enter_shift;
            stop_pend <= (state != S_IDLE) && (state_nx != S_IDLE) && stop_req;
            busy      <= (state_nx != S_IDLE);
            fir_reset <= (state_nx == S_RST);
            out_valid <= (state == S_STREAM) && !shift_cyc;
            out_lsb   <= (state == S_STREAM) && shift_cyc;

            if (state == S_IDLE && coef_we) coef_file[coef_idx] <= coef_data;
            if (state == S_IDLE && start)   mode <= lsb_mode;

            fir_x <= '0;
            if (state_nx == S_MODE) fir_x <= BW_IN'(mode);
            if (state_nx == S_COEF) fir_x <= coef_file[tap_nx];
            if (pop)                fir_x <= fifo_mem[rd_ptr[AW-1:0]];

            if (enter_read && fifo_empty && underrun_cnt != 8'hFF)
                underrun_cnt <= underrun_cnt + 8'd1;

            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= s_data;
    end

endmodule

// File: tb/tb_fir_input_sequencer.sv
// Directed bench for fir_input_sequencer: a per-cycle vector table for load
// and mode-0 streaming, then hand sequences for the multi-cycle corner cases.
module tb_fir_input_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, stop = 1'b0, lsb_mode = 1'b0;
    logic       coef_we = 1'b0;
    logic [1:0] coef_idx = '0;
    logic [5:0] coef_data = '0;
    logic       s_valid = 1'b0;
    logic [5:0] s_data = '0;
    logic       s_ready, fir_reset, busy, out_valid, out_lsb;
    logic [5:0] fir_x;
    logic [7:0] underrun_cnt;

    int total = 0;
    int bad = 0;
    logic [5:0] push_q[$];

    fir_input_sequencer #(.N_TAPS(4), .BW_IN(6), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .lsb_mode(lsb_mode),
        .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .fir_reset(fir_reset), .fir_x(fir_x), .busy(busy),
        .out_valid(out_valid), .out_lsb(out_lsb), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       start, stop, lsb, we;
        logic [1:0] idx;
        logic [5:0] cdata;
        logic       sv;
        logic [5:0] sd;
        logic       e_fr;
        logic [5:0] e_fx;
        logic       e_busy, e_ov, e_ol, e_rdy;
        logic [7:0] e_ur;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t row(input int st, sp, ls, we, idx, cd, sv, sd,
                                 fr, fx, bs, ov, ol, rdy, ur);
        vec_t v;
        v.start = st[0];  v.stop = sp[0];   v.lsb = ls[0];   v.we = we[0];
        v.idx   = idx[1:0]; v.cdata = cd[5:0]; v.sv = sv[0]; v.sd = sd[5:0];
        v.e_fr  = fr[0];  v.e_fx = fx[5:0]; v.e_busy = bs[0];
        v.e_ov  = ov[0];  v.e_ol = ol[0];   v.e_rdy = rdy[0]; v.e_ur = ur[7:0];
        return v;
    endfunction

    function automatic int m6(input int v);
        return v & 63;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // One clock; offers the head of push_q and drops it once accepted.
    task automatic tick();
        logic rdy;
        s_valid = (push_q.size() != 0);
        if (s_valid) s_data = push_q[0];
        rdy = s_ready;
        @(posedge clk);
        #1;
        if (s_valid && rdy) void'(push_q.pop_front());
    endtask

    task automatic strm(input string nm, input int fx, input int ov, input int ol, input int bs);
        tick();
        chk({nm, "_fx"}, int'(fir_x), m6(fx));
        chk({nm, "_ov"}, int'(out_valid), ov);
        chk({nm, "_ol"}, int'(out_lsb), ol);
        chk({nm, "_busy"}, int'(busy), bs);
    endtask

    // start pulse, then RST, MODE and the four coefficient cycles
    task automatic preamble(input string nm, input logic lsb, input int c3, input int c2,
                            input int c1, input int c0);
        int c[4];
        c[0] = c3; c[1] = c2; c[2] = c1; c[3] = c0;
        start = 1'b1; lsb_mode = lsb;
        tick();
        start = 1'b0;
        chk({nm, "_rst"}, int'(fir_reset), 1);
        chk({nm, "_rst_busy"}, int'(busy), 1);
        tick();
        chk({nm, "_mode_rst"}, int'(fir_reset), 0);
        chk({nm, "_mode"}, int'(fir_x), int'(lsb));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("%s_coef%0d", nm, i), int'(fir_x), m6(c[i]));
        end
    endtask

    initial begin
        vecs[0]  = row(0,0,0,1,0, 1, 1, 5,  0, 0,0,0,0,1,0);
        vecs[1]  = row(0,0,0,1,1, 2, 1,-3,  0, 0,0,0,0,1,0);
        vecs[2]  = row(0,0,0,1,2, 3, 1, 7,  0, 0,0,0,0,1,0);
        vecs[3]  = row(0,0,0,1,3,-4, 0, 0,  0, 0,0,0,0,1,0);
        vecs[4]  = row(1,0,0,0,0, 0, 0, 0,  1, 0,1,0,0,1,0);
        vecs[5]  = row(0,0,0,0,0, 0, 0, 0,  0, 0,1,0,0,1,0);
        vecs[6]  = row(0,0,0,0,0, 0, 0, 0,  0,-4,1,0,0,1,0);
        vecs[7]  = row(0,0,0,0,0, 0, 0, 0,  0, 3,1,0,0,1,0);
        vecs[8]  = row(0,0,0,0,0, 0, 0, 0,  0, 2,1,0,0,1,0);
        vecs[9]  = row(0,0,0,0,0, 0, 0, 0,  0, 1,1,0,0,1,0);
        vecs[10] = row(0,0,0,0,0, 0, 0, 0,  0, 5,1,0,0,1,0);
        vecs[11] = row(0,0,0,0,0, 0, 0, 0,  0,-3,1,1,0,1,0);
        vecs[12] = row(0,0,0,0,0, 0, 0, 0,  0, 7,1,1,0,1,0);
        vecs[13] = row(0,0,0,0,0, 0, 0, 0,  0, 0,1,1,0,1,1);
        vecs[14] = row(0,0,0,0,0, 0, 0, 0,  0, 0,1,1,0,1,2);
        vecs[15] = row(0,1,0,0,0, 0, 0, 0,  0, 0,0,1,0,1,2);
        vecs[16] = row(0,0,0,0,0, 0, 0, 0,  0, 0,0,0,0,1,2);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_fr", int'(fir_reset), 1);
        chk("reset_fx", int'(fir_x), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ov", int'(out_valid), 0);
        chk("reset_ol", int'(out_lsb), 0);
        chk("reset_ur", int'(underrun_cnt), 0);
        chk("reset_rdy", int'(s_ready), 1);
        reset = 1'b0;

        // load order + mode 0 stream
        for (int i = 0; i < 17; i++) begin
            start = vecs[i].start; stop = vecs[i].stop; lsb_mode = vecs[i].lsb;
            coef_we = vecs[i].we; coef_idx = vecs[i].idx; coef_data = vecs[i].cdata;
            s_valid = vecs[i].sv; s_data = vecs[i].sd;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_fr", i), int'(fir_reset), int'(vecs[i].e_fr));
            chk($sformatf("vec%0d_fx", i), int'(fir_x), int'(vecs[i].e_fx));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
            chk($sformatf("vec%0d_ov", i), int'(out_valid), int'(vecs[i].e_ov));
            chk($sformatf("vec%0d_ol", i), int'(out_lsb), int'(vecs[i].e_ol));
            chk($sformatf("vec%0d_rdy", i), int'(s_ready), int'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_ur", i), int'(underrun_cnt), int'(vecs[i].e_ur));
        end
        stop = 1'b0;

        // mode 1: 9, shift, 10, stop on that read, trailing shift, idle
        push_q = '{6'd9, 6'd10};
        tick(); tick();
        preamble("m1", 1'b1, -4, 3, 2, 1);
        strm("m1_r9", 9, 0, 0, 1);
        strm("m1_s0", 0, 1, 0, 1);
        strm("m1_r10", 10, 0, 1, 1);
        stop = 1'b1;
        strm("m1_stop_shift", 0, 1, 0, 1);
        stop = 1'b0;
        strm("m1_idle", 0, 0, 1, 0);
        strm("m1_idle2", 0, 0, 0, 0);
        chk("m1_ur", int'(underrun_cnt), 2);
        chk("m1_empty_rdy", int'(s_ready), 1);

        // backpressure: 1..6 offered while idle, FIFO holds 4
        push_q = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6};
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_rdy%0d", i), int'(s_ready), 1);
        end
        tick();
        chk("bp_full", int'(s_ready), 0);
        tick();
        chk("bp_held", push_q.size(), 2);
        chk("bp_still_full", int'(s_ready), 0);
        preamble("bp", 1'b0, -4, 3, 2, 1);
        strm("bp_x1", 1, 0, 0, 1);
        chk("bp_rdy_after_pop", int'(s_ready), 1);
        for (int v = 2; v <= 6; v++) strm($sformatf("bp_x%0d", v), v, 1, 0, 1);
        chk("bp_all_taken", push_q.size(), 0);
        stop = 1'b1;
        strm("bp_stop", 0, 1, 0, 0);
        stop = 1'b0;
        chk("bp_ur", int'(underrun_cnt), 2);

        // mode 1 stop on first read; remaining samples survive into the next session
        push_q = '{6'd20, 6'd21, 6'd22};
        tick(); tick(); tick();
        preamble("ret", 1'b1, -4, 3, 2, 1);
        strm("ret_r20", 20, 0, 0, 1);
        stop = 1'b1;
        strm("ret_shift", 0, 1, 0, 1);
        stop = 1'b0;
        strm("ret_idle", 0, 0, 1, 0);
        preamble("ret2", 1'b0, -4, 3, 2, 1);
        strm("ret2_x21", 21, 0, 0, 1);
        strm("ret2_x22", 22, 1, 0, 1);
        stop = 1'b1;
        strm("ret2_stop", 0, 1, 0, 0);
        stop = 1'b0;
        chk("ret_ur", int'(underrun_cnt), 2);

        // underrun saturation with an empty FIFO
        preamble("sat", 1'b0, -4, 3, 2, 1);
        for (int k = 1; k <= 260; k++) begin
            tick();
            if (k == 252) chk("sat_254", int'(underrun_cnt), 254);
            if (k == 253) chk("sat_255", int'(underrun_cnt), 255);
        end
        chk("sat_hold", int'(underrun_cnt), 255);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("sat_stop_busy", int'(busy), 0);

        // write while busy is dropped, then reset during COEF
        push_q = '{6'd33};
        tick();
        start = 1'b1; lsb_mode = 1'b0;
        tick();
        start = 1'b0;
        chk("mr_rst", int'(fir_reset), 1);
        coef_we = 1'b1; coef_idx = 2'd3; coef_data = 6'd5;
        tick();
        coef_we = 1'b0;
        chk("mr_mode", int'(fir_x), 0);
        tick();
        chk("mr_busy_we_ignored", int'(fir_x), m6(-4));
        tick();
        reset = 1'b1;
        tick();
        chk("mr_fr", int'(fir_reset), 1);
        chk("mr_fx", int'(fir_x), 0);
        chk("mr_busy", int'(busy), 0);
        chk("mr_ur", int'(underrun_cnt), 0);
        chk("mr_ov", int'(out_valid), 0);
        chk("mr_ol", int'(out_lsb), 0);
        chk("mr_rdy", int'(s_ready), 1);
        reset = 1'b0;
        tick();
        chk("mr_idle_fr", int'(fir_reset), 0);
        chk("mr_idle_busy", int'(busy), 0);
        preamble("mr2", 1'b0, 0, 0, 0, 0);
        strm("mr2_flushed", 0, 0, 0, 1);
        chk("mr2_ur", int'(underrun_cnt), 1);
        stop = 1'b1;
        strm("mr2_stop", 0, 1, 0, 0);
        stop = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
